// File: rtl/xlink_bus_initiator_if.sv
// Bundle of request/response, TX token and RX token signals between a local controller,
// the XLink token FIFOs and the bus initiator.
interface xlink_bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [30:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [8:0]  tx_token;
    logic        tx_token_valid;
    logic        tx_token_taken;
    logic [8:0]  rx_token;
    logic        rx_empty;
    logic        rx_ren;

    // Initiator side
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  tx_token_taken, rx_token, rx_empty,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output tx_token, tx_token_valid, rx_ren
    );

    // Controller and token FIFO side
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output tx_token_taken, rx_token, rx_empty,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  tx_token, tx_token_valid, rx_ren
    );
endinterface

// File: rtl/xlink_bus_initiator.sv
// XLink register-access initiator: serialises local read/write requests into request token
// packets and parses the target's ACK/NACK response packet into rsp_rdata/rsp_error.
module xlink_bus_initiator #(
    parameter logic [7:0] CT_WRITE       = 8'hC1,
    parameter logic [7:0] CT_READ        = 8'hC2,
    parameter logic [7:0] CT_END         = 8'h01,
    parameter logic [7:0] CT_ACK         = 8'h03,
    parameter logic [7:0] CT_NACK        = 8'h04,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    xlink_bus_initiator_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // Last counter value seen before the idle count reaches TIMEOUT_CYCLES-1
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [3:0] {
        IDLE, SEND_HDR, SEND_ADDR, SEND_DATA, SEND_END,
        WAIT_ACK, RECV_DATA, WAIT_END, DRAIN, DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      idx_reg, idx_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            write_reg, write_next;
    logic [31:0]     addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic            error_reg, error_next;
    logic [31:0]     rsp_rdata_reg;
    logic            rsp_error_reg;

    logic            tx_valid;
    logic [8:0]      tx_tok;
    logic            ready;
    logic            pop;
    logic            timeout;
    logic            rx_ctrl;
    logic [7:0]      rx_code;

    logic [7:0] addr_bytes  [4];
    logic [7:0] wdata_bytes [4];

    // Byte 0 is the most significant byte, matching wire order
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign addr_bytes[gi]  = addr_reg[31-8*gi -: 8];
            assign wdata_bytes[gi] = wdata_reg[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        error_next = error_reg;
        tx_valid   = 1'b0;
        tx_tok     = '0;
        ready      = 1'b0;
        timeout    = 1'b0;
        rx_ctrl    = bus.rx_token[8];
        rx_code    = bus.rx_token[7:0];
        // Everywhere except DONE the RX head is consumed; outside the wait states it is a stray
        pop        = !reset && !bus.rx_empty && (state_reg != DONE);

        if (state_reg inside {WAIT_ACK, RECV_DATA, WAIT_END, DRAIN}) begin
            if (pop) begin
                count_next = '0;
            end else begin
                count_next = count_reg + CW'(1);
                timeout    = (count_reg == TO_LAST);
            end
        end

        case (state_reg)
            IDLE: begin
                ready = !reset;
                if (bus.req_valid && !reset) begin
                    write_next = bus.req_write;
                    addr_next  = {1'b0, bus.req_addr};
                    wdata_next = bus.req_wdata;
                    rdata_next = '0;
                    error_next = 1'b0;
                    idx_next   = '0;
                    state_next = SEND_HDR;
                end
            end
            SEND_HDR: begin
                tx_valid = 1'b1;
                tx_tok   = {1'b1, write_reg ? CT_WRITE : CT_READ};
                if (bus.tx_token_taken) begin
                    idx_next   = '0;
                    state_next = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                tx_valid = 1'b1;
                tx_tok   = {1'b0, addr_bytes[idx_reg]};
                if (bus.tx_token_taken) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3)
                        state_next = write_reg ? SEND_DATA : SEND_END;
                end
            end
            SEND_DATA: begin
                tx_valid = 1'b1;
                tx_tok   = {1'b0, wdata_bytes[idx_reg]};
                if (bus.tx_token_taken) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3)
                        state_next = SEND_END;
                end
            end
            SEND_END: begin
                tx_valid = 1'b1;
                tx_tok   = {1'b1, CT_END};
                if (bus.tx_token_taken) begin
                    count_next = '0;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (pop) begin
                    if (rx_ctrl && rx_code == CT_ACK) begin
                        idx_next   = '0;
                        state_next = write_reg ? WAIT_END : RECV_DATA;
                    end else if (rx_ctrl && rx_code == CT_NACK) begin
                        error_next = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        error_next = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end
            end
            RECV_DATA: begin
                if (pop) begin
                    if (!rx_ctrl) begin
                        rdata_next = {rdata_reg[23:0], rx_code};
                        idx_next   = idx_reg + 2'd1;
                        if (idx_reg == 2'd3)
                            state_next = WAIT_END;
                    end else begin
                        error_next = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT_END: begin
                if (pop) begin
                    if (rx_ctrl && rx_code == CT_END) begin
                        state_next = DONE;
                    end else begin
                        error_next = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end
            end
            DRAIN: begin
                if (pop) begin
                    if (rx_ctrl && rx_code == CT_END)
                        state_next = DONE;
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            count_reg     <= '0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            error_reg     <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            error_reg <= error_next;
            // Response fields are captured on entry to DONE and held until the next one
            if (state_next == DONE) begin
                rsp_error_reg <= error_next;
                rsp_rdata_reg <= (!write_reg && !error_next) ? rdata_reg : 32'h0;
            end
        end
    end

    assign bus.req_ready      = ready;
    assign bus.tx_token_valid = tx_valid && !reset;
    assign bus.tx_token       = reset ? 9'h000 : tx_tok;
    assign bus.rx_ren         = pop;
    assign bus.rsp_valid      = (state_reg == DONE) && !reset;
    assign bus.rsp_rdata      = rsp_rdata_reg;
    assign bus.rsp_error      = rsp_error_reg;

endmodule

// File: tb/tb_xlink_bus_initiator.sv
// Scoreboard bench for xlink_bus_initiator: expected TX tokens and responses are queued when a
// request is issued and compared as the DUT takes tokens and pulses rsp_valid.
module tb_xlink_bus_initiator;
    localparam int T = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xlink_bus_initiator_if bus();

    xlink_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_cnt = 0;
    int tx_cnt  = 0;
    logic [8:0]  rx_q    [$];
    logic [8:0]  reply_q [$];
    logic [8:0]  exp_tx  [$];
    logic [32:0] exp_rsp [$];
    bit          hold_pend = 1'b0;
    logic [8:0]  hold_tok;
    bit          last_accept;

    task automatic rx_refresh();
        bus.rx_empty = (rx_q.size() == 0);
        bus.rx_token = (rx_q.size() != 0) ? rx_q[0] : 9'h000;
    endtask

    // One clock: sample at negedge, model FIFO pop at posedge, drive new inputs 1 ns later
    task automatic tick();
        logic       pop, take;
        logic [8:0] tok, e;
        logic [32:0] er;
        @(negedge clk);
        pop  = bus.rx_ren;
        take = bus.tx_token_valid && bus.tx_token_taken;
        tok  = bus.tx_token;
        last_accept = bus.req_valid && bus.req_ready;
        if (hold_pend) begin
            n_tests++;
            if (bus.tx_token_valid !== 1'b1 || tok !== hold_tok) begin
                n_fail++;
                $display("FAIL tx_hold: got valid=%b tok=%03h, expected valid=1 tok=%03h",
                         bus.tx_token_valid, tok, hold_tok);
            end
        end
        hold_pend = bus.tx_token_valid && !bus.tx_token_taken;
        hold_tok  = tok;
        if (take) begin
            tx_cnt++;
            n_tests++;
            if (exp_tx.size() == 0) begin
                n_fail++;
                $display("FAIL tx_extra: got tok=%03h, expected no token", tok);
            end else begin
                e = exp_tx.pop_front();
                if (tok !== e) begin
                    n_fail++;
                    $display("FAIL tx_token: got %03h, expected %03h", tok, e);
                end
            end
        end
        if (pop && rx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_ren_empty: got rx_ren=1, expected 0 while RX FIFO empty");
        end
        if (bus.rsp_valid === 1'b1) begin
            rsp_cnt++;
            n_tests++;
            if (exp_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_extra: got rsp err=%b rdata=%08h, expected none",
                         bus.rsp_error, bus.rsp_rdata);
            end else begin
                er = exp_rsp.pop_front();
                if ({bus.rsp_error, bus.rsp_rdata} !== er) begin
                    n_fail++;
                    $display("FAIL rsp_data: got err=%b rdata=%08h, expected err=%b rdata=%08h",
                             bus.rsp_error, bus.rsp_rdata, er[32], er[31:0]);
                end
            end
        end
        @(posedge clk);
        if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
        #1;
        rx_refresh();
    endtask

    // Issue one request, queue its expectations, feed reply_q once the request is sent
    task automatic run_txn(input bit wr, input logic [30:0] addr, input logic [31:0] wdata,
                           input bit toggle, input bit exp_err, input logic [31:0] exp_rdata,
                           input int max_wait, output int lat);
        logic [31:0] a32;
        int n_tok, start_tx, start_rsp;
        a32 = {1'b0, addr};
        exp_tx.push_back({1'b1, wr ? 8'hC1 : 8'hC2});
        for (int i = 0; i < 4; i++) exp_tx.push_back({1'b0, a32[31-8*i -: 8]});
        if (wr) for (int i = 0; i < 4; i++) exp_tx.push_back({1'b0, wdata[31-8*i -: 8]});
        exp_tx.push_back(9'h101);
        exp_rsp.push_back({exp_err, exp_rdata});
        n_tok     = wr ? 10 : 6;
        start_tx  = tx_cnt;
        start_rsp = rsp_cnt;
        bus.req_valid      = 1'b1;
        bus.req_write      = wr;
        bus.req_addr       = addr;
        bus.req_wdata      = wdata;
        bus.tx_token_taken = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        n_tests++;
        if (last_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL req_accept: got accept=%b, expected 1", last_accept);
        end
        lat = 0;
        while (tx_cnt - start_tx < n_tok && lat < 200) begin
            if (toggle) bus.tx_token_taken = ~bus.tx_token_taken;
            tick();
            lat++;
        end
        bus.tx_token_taken = 1'b1;
        n_tests++;
        if (tx_cnt - start_tx != n_tok) begin
            n_fail++;
            $display("FAIL tx_count: got %0d tokens, expected %0d", tx_cnt - start_tx, n_tok);
        end
        foreach (reply_q[i]) rx_q.push_back(reply_q[i]);
        reply_q.delete();
        rx_refresh();
        while (rsp_cnt == start_rsp && lat < max_wait) begin
            tick();
            lat++;
        end
        n_tests++;
        if (rsp_cnt == start_rsp) begin
            n_fail++;
            $display("FAIL rsp_missing: got no rsp_valid within %0d cycles, expected one", max_wait);
            exp_rsp.delete();
        end
        tick();
        n_tests++;
        if (rsp_cnt != start_rsp + 1 || bus.rsp_error !== exp_err || bus.rsp_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rsp_pulse_hold: got pulses=%0d err=%b rdata=%08h, expected 1 %b %08h",
                     rsp_cnt - start_rsp, bus.rsp_error, bus.rsp_rdata, exp_err, exp_rdata);
        end
        $display("[TB] txn %s addr=%08h err=%b rdata=%08h lat=%0d",
                 wr ? "WR" : "RD", a32, bus.rsp_error, bus.rsp_rdata, lat);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.tx_token_taken = 1'b1;
        reset = 1'b1;
        rx_q.push_back(9'h055);
        rx_refresh();
        tick(); tick();
        n_tests++;
        if (bus.req_ready !== 1'b0 || bus.tx_token_valid !== 1'b0 || bus.tx_token !== 9'h000 ||
            bus.rx_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b txv=%b tok=%03h ren=%b, expected 0 0 000 0",
                     bus.req_ready, bus.tx_token_valid, bus.tx_token, bus.rx_ren);
        end
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: got v=%b rdata=%08h err=%b, expected 0 0 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_error);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.rx_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready=%b ren=%b, expected 1 1",
                     bus.req_ready, bus.rx_ren);
        end
        tick();
        n_tests++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL stray_pop: got %0d tokens left, expected 0", rx_q.size());
        end
    endtask

    task automatic test_write();
        int lat;
        reply_q = '{9'h103, 9'h101};
        run_txn(1'b1, 31'h7F000080, 32'h81000000, 1'b0, 1'b0, 32'h0, 100, lat);
        n_tests++;
        if (lat != 13) begin
            n_fail++;
            $display("FAIL write_latency: got %0d cycles, expected 13", lat);
        end
    endtask

    task automatic test_read_toggle();
        int lat;
        reply_q = '{9'h103, 9'h0DE, 9'h0AD, 9'h0BE, 9'h0EF, 9'h101};
        run_txn(1'b0, 31'h00001234, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 200, lat);
    endtask

    task automatic test_nack();
        int lat;
        reply_q = '{9'h104, 9'h101};
        run_txn(1'b0, 31'h00000400, 32'h0, 1'b0, 1'b1, 32'h0, 100, lat);
        n_tests++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL nack_drain: got %0d tokens left, expected 0", rx_q.size());
        end
    endtask

    task automatic test_early_end();
        int lat;
        reply_q = '{9'h103, 9'h011, 9'h101, 9'h101};
        run_txn(1'b0, 31'h00000010, 32'h0, 1'b0, 1'b1, 32'h0, 100, lat);
        n_tests++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL early_end_drain: got %0d tokens left, expected 0", rx_q.size());
        end
        reply_q = '{9'h103, 9'h011, 9'h101};
        run_txn(1'b0, 31'h00000020, 32'h0, 1'b0, 1'b1, 32'h0, T + 100, lat);
        n_tests++;
        if (lat != 9 + T) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d cycles, expected %0d", lat, 9 + T);
        end
    endtask

    task automatic test_write_timeout();
        int lat, cnt0;
        run_txn(1'b1, 31'h00000044, 32'h55667788, 1'b0, 1'b1, 32'h0, T + 100, lat);
        n_tests++;
        if (lat != 10 + T) begin
            n_fail++;
            $display("FAIL write_timeout: got %0d cycles, expected %0d", lat, 10 + T);
        end
        cnt0 = rsp_cnt;
        rx_q.push_back(9'h103);
        rx_q.push_back(9'h101);
        rx_refresh();
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (rsp_cnt != cnt0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL late_reply: got pulses=%0d left=%0d, expected 0 0",
                     rsp_cnt - cnt0, rx_q.size());
        end
        reply_q = '{9'h103, 9'h001, 9'h002, 9'h003, 9'h004, 9'h101};
        run_txn(1'b0, 31'h00000048, 32'h0, 1'b0, 1'b0, 32'h01020304, 100, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        rx_q.push_back(9'h0AA);
        rx_q.push_back(9'h103);
        rx_refresh();
        reply_q = '{9'h103, 9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h101};
        run_txn(1'b0, 31'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 32'hFF00FF00, 100, lat);
        reply_q = '{9'h103, 9'h101};
        run_txn(1'b1, 31'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 100, lat);
        reply_q = '{9'h103, 9'h012, 9'h034, 9'h056, 9'h078, 9'h101};
        run_txn(1'b0, 31'h00000008, 32'h0, 1'b0, 1'b0, 32'h12345678, 100, lat);
    endtask

    task automatic test_reset_mid();
        int lat, cnt0;
        exp_tx.push_back(9'h1C1);
        exp_tx.push_back(9'h012);
        cnt0 = rsp_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 31'h12345678; bus.req_wdata = 32'hCAFEF00D;
        bus.tx_token_taken = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.tx_token_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_txv: got %b, expected 0", bus.tx_token_valid);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b, expected 1", bus.req_ready);
        end
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (rsp_cnt != cnt0 || exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_abandon: got pulses=%0d pending_tx=%0d, expected 0 0",
                     rsp_cnt - cnt0, exp_tx.size());
        end
        exp_tx.delete();
        reply_q = '{9'h103, 9'h0CA, 9'h0FE, 9'h0F0, 9'h00D, 9'h101};
        run_txn(1'b0, 31'h00000100, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 100, lat);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_toggle();
        test_nack();
        test_early_end();
        test_write_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
